// File: rtl/jtframe_scan_half_if.sv
// Video bus between the 31 kHz source and the line-rate halver.
// The source side drives the doubled stream and controls; the halver returns native video.
interface jtframe_scan_half_if #(
    parameter int COLORW = 4
);
    localparam int DW = 3 * COLORW;

    logic          pxl2_cen;
    logic          pxl_cen;
    logic [DW-1:0] x2_pxl;
    logic          x2_HS;
    logic          line_sel;
    logic          vblend;
    logic [DW-1:0] base_pxl;
    logic          base_HS;

    modport master (
        output pxl2_cen, pxl_cen, x2_pxl, x2_HS, line_sel, vblend,
        input  base_pxl, base_HS
    );

    modport slave (
        input  pxl2_cen, pxl_cen, x2_pxl, x2_HS, line_sel, vblend,
        output base_pxl, base_HS
    );
endinterface

// File: rtl/jtframe_scan_half.sv
// Line-rate halver: rebuilds native 15 kHz video from scan-doubled 31 kHz video
// using a two-bank line buffer, with optional averaging of each line pair.
module jtframe_scan_half #(
    parameter int COLORW = 4,
    parameter int HLEN   = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    jtframe_scan_half_if.slave vid
);
    localparam int DW = 3 * COLORW;
    localparam int AW = (HLEN <= 512) ? 9 : 10;
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
    localparam logic [DW-1:0] PXL_ZERO  = {DW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } wr_state_t;

    // Per-channel floor average, carried in COLORW+1 bits so the sum never overflows
    function automatic logic [DW-1:0] blend_pxl(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]   res;
        logic [COLORW:0] sum;
        res = PXL_ZERO;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, a[c*COLORW +: COLORW]} + {1'b0, b[c*COLORW +: COLORW]};
            res[c*COLORW +: COLORW] = sum[COLORW:1];
        end
        return res;
    endfunction

    logic          last_hs_r, pair_r, alt_r, bank_r;
    logic [AW-1:0] wraddr_r, hscnt_r, hlen_r, hswidth_r, rdaddr_r;
    logic          start_pend_r;
    logic [AW:0]   wr_addr_r;
    logic [DW-1:0] wr_pxl_r, rmw_q_r, q_r;
    logic          rmw_mode_r;
    logic [DW-1:0] base_pxl_r;
    logic          base_hs_r;
    logic [DW-1:0] mem [0:(2**(AW+1))-1];
    wr_state_t     state_r, state_s;

    logic          hs_posedge_s, line_done_s, capture_s, keep_s, rmw_s, start_s;
    logic          mem_we_s;
    logic [DW-1:0] mem_wdata_s;

    assign vid.base_pxl = base_pxl_r;
    assign vid.base_HS  = base_hs_r;

    // Input-side decode and write-port sequencing
    always_comb begin
        hs_posedge_s = vid.x2_HS & ~last_hs_r;
        line_done_s  = vid.pxl2_cen & hs_posedge_s & pair_r;
        capture_s    = vid.pxl2_cen & ~hs_posedge_s & ~alt_r;
        keep_s       = vid.vblend | (pair_r == vid.line_sel);
        rmw_s        = vid.vblend & pair_r;
        start_s      = start_pend_r | line_done_s;
        state_s      = state_r;
        mem_we_s     = 1'b0;
        mem_wdata_s  = wr_pxl_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s && keep_s) begin
                    state_s = rmw_s ? ST_READ : ST_WRITE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = rmw_mode_r ? blend_pxl(rmw_q_r, wr_pxl_r) : wr_pxl_r;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Write-port state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch each kept pixel with its address so the RMW has stable operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r  <= {(AW+1){1'b0}};
            wr_pxl_r   <= PXL_ZERO;
            rmw_mode_r <= 1'b0;
        end else if (capture_s && keep_s) begin
            wr_addr_r  <= {~bank_r, wraddr_r};
            wr_pxl_r   <= vid.x2_pxl;
            rmw_mode_r <= rmw_s;
        end
    end

    // Line buffer: one write port, one read port per side
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_addr_r] <= mem_wdata_s;
        end
        rmw_q_r <= mem[wr_addr_r];
        q_r     <= mem[{bank_r, rdaddr_r}];
    end

    // Input timing: capture first copy of each pixel, measure line and HS, swap banks per pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_hs_r <= 1'b0;
            pair_r    <= 1'b0;
            alt_r     <= 1'b0;
            bank_r    <= 1'b0;
            wraddr_r  <= ADDR_ZERO;
            hscnt_r   <= ADDR_ZERO;
            hlen_r    <= ADDR_ZERO;
            hswidth_r <= ADDR_ZERO;
        end else if (vid.pxl2_cen) begin
            last_hs_r <= vid.x2_HS;
            if (hs_posedge_s) begin
                wraddr_r <= ADDR_ZERO;
                alt_r    <= 1'b0;
                hscnt_r  <= ADDR_ZERO;
                pair_r   <= ~pair_r;
                if (pair_r) begin
                    hlen_r    <= wraddr_r;
                    hswidth_r <= hscnt_r;
                    bank_r    <= ~bank_r;
                end
            end else begin
                alt_r <= ~alt_r;
                // Saturate instead of wrapping so long lines never corrupt the start
                if (!alt_r && (wraddr_r != ADDR_MAX)) begin
                    wraddr_r <= wraddr_r + ADDR_ONE;
                end
                if (vid.x2_HS && (hscnt_r != ADDR_MAX)) begin
                    hscnt_r <= hscnt_r + ADDR_ONE;
                end
            end
        end
    end

    // Output timing at native rate; a line start is held until the next pxl_cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend_r <= 1'b0;
            rdaddr_r     <= ADDR_ZERO;
            base_pxl_r   <= PXL_ZERO;
            base_hs_r    <= 1'b0;
        end else if (vid.pxl_cen) begin
            start_pend_r <= 1'b0;
            base_pxl_r   <= (rdaddr_r < hlen_r) ? q_r : PXL_ZERO;
            if (start_s) begin
                rdaddr_r  <= ADDR_ZERO;
                base_hs_r <= 1'b1;
            end else begin
                if (rdaddr_r < hlen_r) begin
                    rdaddr_r <= rdaddr_r + ADDR_ONE;
                end
                if (rdaddr_r == hswidth_r) begin
                    base_hs_r <= 1'b0;
                end
            end
        end else if (line_done_s) begin
            start_pend_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtframe_scan_half.sv
// Directed bench for jtframe_scan_half: drives doubled lines pair by pair and
// checks every native pixel/HS tick against hand-derived per-line expectations.
module tb_jtframe_scan_half;
    localparam int COLORW = 4;
    localparam int DW     = 3 * COLORW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   tcount   = 0;
    logic tb_pair    = 1'b0;
    logic tb_last_hs = 1'b0;
    logic out_on     = 1'b0;
    int   out_hlen = 0, out_hsw = 0, out_kind = -1, out_k = 0;
    int   done_hlen = 0, done_hsw = 0, done_kind = -1;

    jtframe_scan_half_if #(.COLORW(COLORW)) vid ();

    jtframe_scan_half #(.COLORW(COLORW), .HLEN(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0 junk, 1 line A, 2 line B, 3/4 blend operands, 5/6 ramps, 7 expected blend result
    function automatic logic [DW-1:0] pat_val(input int pat, input int i);
        case (pat)
            0:       return 12'h5A5;
            1:       return 12'((i % 14 + 1) * 273);
            2:       return 12'hFFF;
            3:       return 12'h0F0;
            4:       return 12'h0E2;
            5:       return 12'(i * 3 + 64);
            6:       return 12'(i * 5 + 291);
            7:       return 12'h0E1;
            default: return 12'h000;
        endcase
    endfunction

    task automatic check_outputs();
        if (!out_on) begin
            check_val("idle_pxl", 32'(vid.base_pxl), 32'd0);
            check_val("idle_hs", 32'(vid.base_HS), 32'd0);
        end else begin
            check_val($sformatf("hs k=%0d", out_k), 32'(vid.base_HS), 32'(out_k <= out_hsw));
            if (out_k > 0) begin
                if (out_k - 1 >= out_hlen) begin
                    check_val($sformatf("blank k=%0d", out_k), 32'(vid.base_pxl), 32'd0);
                end else if (out_kind >= 0) begin
                    check_val($sformatf("pxl k=%0d", out_k), 32'(vid.base_pxl),
                              32'(pat_val(out_kind, out_k - 1)));
                end
            end
        end
    endtask

    task automatic pxl2_tick(input logic hs, input logic [DW-1:0] pix);
        logic cen_out;
        logic start;
        cen_out = (tcount % 2 == 0);
        start   = hs && !tb_last_hs && tb_pair;
        if (hs && !tb_last_hs) tb_pair = ~tb_pair;
        tb_last_hs   = hs;
        vid.x2_HS    = hs;
        vid.x2_pxl   = pix;
        vid.pxl2_cen = 1'b1;
        vid.pxl_cen  = cen_out;
        @(negedge clk);
        if (start) begin
            out_on   = 1'b1;
            out_hlen = done_hlen;
            out_hsw  = done_hsw;
            out_kind = done_kind;
            out_k    = 0;
        end else if (cen_out) begin
            out_k++;
        end
        if (cen_out) check_outputs();
        vid.pxl2_cen = 1'b0;
        vid.pxl_cen  = 1'b0;
        repeat (3) @(negedge clk);
        tcount++;
    endtask

    task automatic run_line(input int n, input int h, input int pat);
        for (int j = 0; j < n; j++) begin
            pxl2_tick(j < h, pat_val(pat, j / 2));
        end
    endtask

    task automatic run_pair(input int n, input int h, input int p0, input int p1,
                            input logic vb, input logic sel, input int kind);
        vid.vblend   = vb;
        vid.line_sel = sel;
        run_line(n, h, p0);
        run_line(n, h, p1);
        done_hlen = (n / 2 > 511) ? 511 : n / 2;
        done_hsw  = h - 1;
        done_kind = kind;
    endtask

    initial begin
        vid.pxl2_cen = 1'b0;
        vid.pxl_cen  = 1'b0;
        vid.x2_pxl   = 12'h000;
        vid.x2_HS    = 1'b0;
        vid.line_sel = 1'b0;
        vid.vblend   = 1'b0;
        repeat (4) @(negedge clk);
        check_val("reset_pxl", 32'(vid.base_pxl), 32'd0);
        check_val("reset_hs", 32'(vid.base_HS), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone line after reset: output must stay idle through it
        run_line(64, 8, 0);
        done_hlen = 32; done_hsw = 7; done_kind = -1;

        run_pair(640, 32, 1, 2, 1'b0, 1'b0, 1);     // keep first line
        run_pair(640, 32, 3, 4, 1'b1, 1'b0, 7);     // vertical blend
        run_pair(640, 32, 5, 6, 1'b0, 1'b1, 6);     // keep second line
        run_pair(1200, 16, 5, 6, 1'b0, 1'b1, 6);    // overflow
        run_pair(1200, 16, 5, 6, 1'b0, 1'b1, 6);    // shows overflow line in full
        run_pair(512, 20, 5, 6, 1'b0, 1'b1, 6);     // 256-pixel pairs
        run_pair(640, 32, 5, 6, 1'b0, 1'b1, 6);     // 320-pixel pairs
        run_line(20, 32, 5);                        // partial line, output mid-HS

        // Asynchronous reset in the middle of an output line
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_pxl", 32'(vid.base_pxl), 32'd0);
        check_val("midrst_hs", 32'(vid.base_HS), 32'd0);
        out_on     = 1'b0;
        tb_pair    = 1'b0;
        tb_last_hs = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_line(64, 8, 0);
        done_hlen = 32; done_hsw = 7; done_kind = 0;
        run_line(64, 8, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/jtframe_scan_half.md
Name: jtframe_scan_half

Overview:
Line-rate halver: the inverse of the team's scan doubler. It takes 31 kHz doubled video (each native pixel repeated twice horizontally, each line sent twice) and rebuilds native 15 kHz video for analogue/CRT output. A two-bank line buffer captures one input line pair while the previous pair is read out at native pixel rate. An optional vertical blend averages the two lines of each pair.

Parameters:
COLORW, 4, bits per colour channel; DW=3*COLORW
HLEN, 512, max native pixels per line; AW=9 if HLEN<=512 else 10

Ports:
clk  in  1  system clock, at least 4x pxl2_cen rate
rst_n  in  1  asynchronous, active-low reset
pxl2_cen  in  1  input (doubled) pixel clock enable
pxl_cen  in  1  output (native) pixel clock enable, half pxl2_cen rate
x2_pxl  in  DW  doubled-rate pixel, RGB packed MSB=R
x2_HS  in  1  doubled-rate horizontal sync, active high
line_sel  in  1  which line of a pair is kept when vblend=0 (0=first, 1=second)
vblend  in  1  1 = output average of both lines of the pair
base_pxl  out  DW  native-rate pixel
base_HS  out  1  native-rate horizontal sync, active high

Behaviour:
- Reset (async): base_pxl=0, base_HS=0. wraddr, rdaddr, hlen, hswidth, pair, alt and bank all 0. Reset mid-line aborts both sides; output stays black with HS low until the first complete pair.
- Input side, all updates only on pxl2_cen:
  - last_HS<=x2_HS. HS_posedge = x2_HS & !last_HS.
  - On HS_posedge: wraddr<=0, alt<=0, hscnt<=0, pair<=~pair.
  - If the pair just completed (pair==1 before the toggle): hlen<=wraddr, hswidth<=hscnt, bank<=~bank, and start an output line.
- Writes go to bank ~bank (the input-side bank) at address {~bank, wraddr}.
  - A pixel is captured when alt==0. alt toggles on every pxl2_cen, so only the first copy of each doubled pixel is kept.
  - wraddr increments after each capture and saturates at 2^AW-1 (no wrap). Captures past saturation overwrite the last entry.
- vblend=0: only the line with pair==line_sel is written; the other line is ignored.
- vblend=1:
  - pair 0 writes raw pixels.
  - pair 1 does a read-modify-write at the same address: per channel, floor((stored+new)/2), computed with COLORW+1 bits and taking the top COLORW bits.
  - The RMW completes within 3 clk of the capturing pxl2_cen (clk>=4x pxl2_cen guarantees this).
- hscnt counts pxl2_cen ticks while x2_HS is high, saturating at 2^AW-1.
- Output side, on pxl_cen:
  - Line start: rdaddr<=0 and base_HS<=1.
  - Each pxl_cen: rdaddr increments; base_HS<=0 when rdaddr==hswidth.
  - When rdaddr reaches hlen it stops there, and base_pxl is forced to 0 (blanking) for the rest of the line.
  - Output HS therefore lasts hswidth pxl_cen ticks, which is the same wall time as 2*hswidth pxl2 ticks, i.e. the native HS width.
- Read data is registered: base_pxl takes RAM q for address N on the pxl_cen following the one that issued N. Latency is 1 pxl_cen, plus 1 clk RAM latency.
- Before the first full pair hlen=0, so the output is all black.
- Simultaneous HS_posedge and the last capture: the capture is dropped and the HS reset wins.
- A line start that arrives while the output side is mid-line restarts the output immediately; no two line starts are ever merged.

Test Plan:
1. Reset behaviour: assert rst_n=0 mid-stream -> base_pxl=0 and base_HS=0 asynchronously; after release, output stays black until 2 input HS posedges have occurred.
2. Keep first line: COLORW=4, vblend=0, line_sel=0; line A is 0x111,0x111,0x222,0x222,...; line B is 0xFFF everywhere -> output is 0x111,0x222,... and never 0xFFF.
3. Vertical blend: vblend=1; line A is 0x0F0 and line B is 0x0E2 for all pixels -> base_pxl=0x0E1.
4. HS width: x2_HS high for 32 pxl2_cen ticks, line length 2*320 ticks -> base_HS high for 32 pxl_cen ticks, followed by 320 valid pixels then black.
5. Overflow: 600 doubled pixels per line with HLEN=512 -> wraddr saturates at 511, no wrap; entry 511 holds the last captured pixel.
6. Line-length change: 256-pixel pairs then 320-pixel pairs -> the first output line after the change still shows 256 pixels, and the following line shows 320.
